// File: rtl/jt89_noise_pkg.sv
// jt89_noise_pkg
// Shared constants for the JT89 noise channel: rate-counter reload values
// per NF setting, the LFSR seed and a decoded view of the control register.
package jt89_noise_pkg;

   // Rate-counter reload values selected by NF. NF = 3 hands the shift
   // clock to tone channel 2; the counter keeps running with the NF = 0 value.
   localparam logic [6:0] NF0_RELOAD = 7'd16;
   localparam logic [6:0] NF1_RELOAD = 7'd32;
   localparam logic [6:0] NF2_RELOAD = 7'd64;

   // Seed loaded at reset and on every control write.
   localparam logic [15:0] JT89_LFSR_INIT = 16'h8000;

   // Noise control register: FB (1 = white, 0 = periodic) and NF rate select.
   typedef struct packed {
      logic       fb;
      logic [1:0] nf;
   } noise_ctrl_t;

   function automatic logic [6:0] nf_reload(input logic [1:0] nf);
      logic [6:0] n;
      case (nf)
         2'd1:    n = NF1_RELOAD;
         2'd2:    n = NF2_RELOAD;
         default: n = NF0_RELOAD;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jt89_vol.sv
// jt89_vol
// Attenuation table shared by the tone and noise channels: maps a 4-bit
// attenuation (2 dB steps, 0 = loudest, 15 = silent) to a 9-bit unsigned
// amplitude, registered.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   vol      : attenuation code
//   amp      : registered amplitude, 0..511
module jt89_vol (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] vol,
   output logic [8:0] amp
);

   logic [8:0] amp_d;

   always_comb begin
      amp_d = 9'd0;
      case (vol)
         4'd0:  amp_d = 9'd511;
         4'd1:  amp_d = 9'd406;
         4'd2:  amp_d = 9'd322;
         4'd3:  amp_d = 9'd256;
         4'd4:  amp_d = 9'd203;
         4'd5:  amp_d = 9'd162;
         4'd6:  amp_d = 9'd128;
         4'd7:  amp_d = 9'd102;
         4'd8:  amp_d = 9'd81;
         4'd9:  amp_d = 9'd64;
         4'd10: amp_d = 9'd51;
         4'd11: amp_d = 9'd41;
         4'd12: amp_d = 9'd32;
         4'd13: amp_d = 9'd26;
         4'd14: amp_d = 9'd20;
         default: amp_d = 9'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) amp <= 9'd0;
      else     amp <= amp_d;
   end

endmodule

// File: rtl/jt89_noise.sv
// jt89_noise
// Noise channel of the JT89 PSG. A 7-bit rate counter (or tone channel 2's
// rising edge when NF = 3) clocks an LFSR; the LFSR output bit gates the
// attenuation-table amplitude sent to the mixer.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   clk_en   : tone-rate tick; all counting is qualified by it
//   ctrl     : {FB, NF[1:0]} noise control register
//   ctrl_wr  : one-cycle pulse on a control-register write
//   vol      : attenuation code, 0 = loudest, 15 = silent
//   ch2_edge : one-cycle pulse (with clk_en) on tone 2 rising edge
//   noise    : 9-bit unsigned amplitude to the mixer
module jt89_noise
   import jt89_noise_pkg::*;
#(
   parameter int                LFSR_W    = 16,
   parameter int                TAP       = 3,
   parameter logic [LFSR_W-1:0] LFSR_INIT = LFSR_W'(JT89_LFSR_INIT)
) (
   input  logic       rst,
   input  logic       clk,
   input  logic       clk_en,
   input  logic [2:0] ctrl,
   input  logic       ctrl_wr,
   input  logic [3:0] vol,
   input  logic       ch2_edge,
   output logic [8:0] noise
);

   noise_ctrl_t       cfg;
   logic [6:0]        cnt;
   logic              half;
   logic [LFSR_W-1:0] lfsr;
   logic              gate_q;
   logic [8:0]        amp;
   logic              reload;
   logic              shift_en;
   logic              fb;

   assign cfg = ctrl;

   // The counter reloads every N ticks and toggles half; a shift is taken on
   // the reload that closes a full half-cycle pair, so the first shift after
   // reset or a write lands 2N ticks later and then every 2N ticks.
   assign reload   = clk_en && (cnt == 7'd1);
   assign shift_en = (cfg.nf == 2'd3) ? (clk_en && ch2_edge) : (reload && half);
   assign fb       = cfg.fb ? (lfsr[0] ^ lfsr[TAP]) : lfsr[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= NF0_RELOAD;
         half   <= 1'b0;
         lfsr   <= LFSR_INIT;
         gate_q <= 1'b0;
      end else begin
         gate_q <= lfsr[0];
         // A control write overrides any reload or shift on the same clk.
         if (ctrl_wr) begin
            cnt  <= nf_reload(cfg.nf);
            half <= 1'b0;
            lfsr <= LFSR_INIT;
         end else begin
            if (clk_en) begin
               if (reload) begin
                  cnt  <= nf_reload(cfg.nf);
                  half <= ~half;
               end else begin
                  cnt  <= cnt - 7'd1;
               end
            end
            if (shift_en) lfsr <= {fb, lfsr[LFSR_W-1:1]};
         end
      end
   end

   jt89_vol u_vol (
      .clk (clk),
      .rst (rst),
      .vol (vol),
      .amp (amp)
   );

   // Both operands come straight from flops, so the output is glitch-free and
   // a change of either the LFSR bit or vol shows up exactly one clk later.
   assign noise = gate_q ? amp : 9'd0;

endmodule

// File: tb/tb_jt89_noise.sv
module tb_jt89_noise;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_en;
   logic [2:0] ctrl;
   logic       ctrl_wr;
   logic [3:0] vol;
   logic       ch2_edge;
   logic [8:0] noise;

   int n_checks = 0;
   int n_fail   = 0;

   int tbl [16] = '{511, 406, 322, 256, 203, 162, 128, 102,
                    81, 64, 51, 41, 32, 26, 20, 0};

   // Reference model: channel state as "ticks since last write" and the LFSR
   // value, advanced by the stated rules rather than by a counter replica.
   logic [15:0] m_lfsr;
   int          m_ticks;
   logic [8:0]  m_noise;

   always #5 clk = ~clk;

   jt89_noise dut (
      .rst      (rst),
      .clk      (clk),
      .clk_en   (clk_en),
      .ctrl     (ctrl),
      .ctrl_wr  (ctrl_wr),
      .vol      (vol),
      .ch2_edge (ch2_edge),
      .noise    (noise)
   );

   function automatic logic [15:0] sw_shift(input logic [15:0] l, input logic white);
      logic b;
      b = white ? (l[0] ^ l[3]) : l[0];
      return {b, l[15:1]};
   endfunction

   function automatic int period_ticks(input logic [1:0] nf);
      return 2 * (16 << nf);
   endfunction

   // Drive one clk of inputs, advance the model, and score the outputs.
   task automatic cycle(input logic en, input logic ch2, input logic wr,
                        input logic [2:0] c, input logic [3:0] v);
      logic [15:0] pre;
      clk_en = en; ch2_edge = ch2; ctrl_wr = wr; ctrl = c; vol = v;
      @(posedge clk); #1;
      pre = m_lfsr;
      m_noise = pre[0] ? 9'(tbl[v]) : 9'd0;
      if (wr) begin
         m_lfsr  = 16'h8000;
         m_ticks = 0;
      end else if (en) begin
         m_ticks++;
         if ((c[1:0] == 2'd3 && ch2) ||
             (c[1:0] != 2'd3 && (m_ticks % period_ticks(c[1:0])) == 0))
            m_lfsr = sw_shift(m_lfsr, c[2]);
      end
      n_checks++;
      if (noise !== m_noise) begin
         n_fail++;
         $display("FAIL noise t=%0t got=%0d exp=%0d", $time, noise, m_noise);
      end
      n_checks++;
      if (dut.lfsr !== m_lfsr) begin
         n_fail++;
         $display("FAIL lfsr t=%0t got=%h exp=%h", $time, dut.lfsr, m_lfsr);
      end
      n_checks++;
      if (dut.lfsr === 16'h0000) begin
         n_fail++;
         $display("FAIL lfsr_zero t=%0t got=%h exp=nonzero", $time, dut.lfsr);
      end
   endtask

   task automatic tick_gap(input logic [2:0] c, input logic [3:0] v);
      cycle(1'b1, 1'b0, 1'b0, c, v);
      repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0, 1'b0, c, v);
   endtask

   task automatic test_reset;
      rst = 1'b1; clk_en = 0; ctrl_wr = 0; ch2_edge = 0; ctrl = 3'b000; vol = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (noise !== 9'd0) begin n_fail++; $display("FAIL reset_noise got=%0d exp=0", noise); end
      rst = 1'b0;
      m_lfsr = 16'h8000; m_ticks = 0;
      n_checks++;
      if (dut.lfsr !== 16'h8000) begin n_fail++; $display("FAIL reset_lfsr got=%h exp=8000", dut.lfsr); end
      n_checks++;
      if (dut.cnt !== 7'd16) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=16", dut.cnt); end
      n_checks++;
      if (dut.half !== 1'b0) begin n_fail++; $display("FAIL reset_half got=%b exp=0", dut.half); end
      repeat (40) cycle(1'b1, 1'b0, 1'b0, 3'b000, 4'd0);
   endtask

   task automatic test_periodic;
      int first_hi;
      int hi_cnt;
      first_hi = -1; hi_cnt = 0;
      cycle(1'b0, 1'b0, 1'b1, 3'b000, 4'd0);
      cycle(1'b0, 1'b0, 1'b0, 3'b000, 4'd0);
      // noise is sampled just before tick k, so it reflects the state after k-1 ticks.
      for (int k = 1; k <= 1024; k++) begin
         if (noise == 9'd511) begin
            hi_cnt++;
            if (first_hi < 0) first_hi = k - 1;
         end
         tick_gap(3'b000, 4'd0);
      end
      n_checks++;
      if (first_hi != 480) begin n_fail++; $display("FAIL periodic_first_high got=%0d exp=480", first_hi); end
      n_checks++;
      if (hi_cnt != 64) begin n_fail++; $display("FAIL periodic_high_ticks got=%0d exp=64", hi_cnt); end
   endtask

   task automatic test_white;
      logic [15:0] sw;
      logic [8:0]  exp_v;
      int          hi;
      sw = 16'h8000; hi = 0;
      cycle(1'b0, 1'b0, 1'b1, 3'b110, 4'd5);
      for (int s = 0; s < 64; s++) begin
         repeat (128) cycle(1'b1, 1'b0, 1'b0, 3'b110, 4'd5);
         cycle(1'b0, 1'b0, 1'b0, 3'b110, 4'd5);
         sw = sw_shift(sw, 1'b1);
         exp_v = sw[0] ? 9'd162 : 9'd0;
         if (sw[0]) hi++;
         n_checks++;
         if (noise !== exp_v) begin
            n_fail++;
            $display("FAIL white_bit%0d got=%0d exp=%0d", s, noise, exp_v);
         end
      end
      n_checks++;
      if (hi == 0 || hi == 64) begin n_fail++; $display("FAIL white_mix got=%0d highs exp=both levels", hi); end
   endtask

   task automatic test_ch2;
      logic [15:0] prev;
      int          shifts;
      shifts = 0;
      cycle(1'b0, 1'b0, 1'b1, 3'b011, 4'd2);
      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 5)) begin
            prev = dut.lfsr;
            cycle(1'b1, 1'b0, 1'b0, 3'b011, 4'd2);
            if (dut.lfsr !== prev) shifts++;
            repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 1'b0, 3'b011, 4'd2);
         end
         prev = dut.lfsr;
         cycle(1'b1, 1'b1, 1'b0, 3'b011, 4'd2);
         if (dut.lfsr !== prev) shifts++;
      end
      n_checks++;
      if (shifts != 10) begin n_fail++; $display("FAIL nf3_shifts got=%0d exp=10", shifts); end
      shifts = 0;
      cycle(1'b0, 1'b0, 1'b1, 3'b001, 4'd2);
      for (int i = 0; i < 10; i++) begin
         prev = dut.lfsr;
         cycle(1'b1, 1'b1, 1'b0, 3'b001, 4'd2);
         if (dut.lfsr !== prev) shifts++;
         repeat ($urandom_range(0, 2)) cycle(1'b1, 1'b0, 1'b0, 3'b001, 4'd2);
      end
      n_checks++;
      if (shifts != 0) begin n_fail++; $display("FAIL nf1_ch2_shifts got=%0d exp=0", shifts); end
   endtask

   task automatic test_back_to_back;
      int wait_t;
      cycle(1'b0, 1'b0, 1'b1, 3'b001, 4'd1);
      repeat (63) cycle(1'b1, 1'b0, 1'b0, 3'b001, 4'd1);
      // Tick 64 would shift; the write on the same clk must win.
      cycle(1'b1, 1'b0, 1'b1, 3'b001, 4'd1);
      n_checks++;
      if (dut.lfsr !== 16'h8000) begin n_fail++; $display("FAIL b2b_lfsr got=%h exp=8000", dut.lfsr); end
      n_checks++;
      if (dut.half !== 1'b0) begin n_fail++; $display("FAIL b2b_half got=%b exp=0", dut.half); end
      n_checks++;
      if (dut.cnt !== 7'd32) begin n_fail++; $display("FAIL b2b_cnt got=%0d exp=32", dut.cnt); end
      wait_t = 0;
      while (dut.lfsr === 16'h8000 && wait_t < 200) begin
         cycle(1'b1, 1'b0, 1'b0, 3'b001, 4'd1);
         wait_t++;
      end
      n_checks++;
      if (wait_t != 64) begin n_fail++; $display("FAIL b2b_next_shift got=%0d exp=64", wait_t); end
   endtask

   task automatic test_vol_sweep;
      logic [3:0] v;
      cycle(1'b0, 1'b0, 1'b1, 3'b000, 4'd0);
      repeat (480) cycle(1'b1, 1'b0, 1'b0, 3'b000, 4'd0);
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         cycle(1'b0, 1'b0, 1'b0, 3'b000, v);
         n_checks++;
         if (noise !== 9'(tbl[i])) begin
            n_fail++;
            $display("FAIL vol_sweep%0d got=%0d exp=%0d", i, noise, tbl[i]);
         end
      end
      n_checks++;
      if (noise !== 9'd0) begin n_fail++; $display("FAIL vol15_silent got=%0d exp=0", noise); end
      repeat (8) begin
         v = 4'($urandom_range(0, 15));
         cycle(1'b0, 1'b0, 1'b0, 3'b000, v);
      end
   endtask

   task automatic test_reset_mid;
      cycle(1'b0, 1'b0, 1'b0, 3'b000, 4'd3);
      n_checks++;
      if (noise !== 9'd256) begin n_fail++; $display("FAIL pre_reset_noise got=%0d exp=256", noise); end
      #2 rst = 1'b1; ctrl = 3'b000;
      #1;
      n_checks++;
      if (noise !== 9'd0) begin n_fail++; $display("FAIL reset_mid_noise got=%0d exp=0", noise); end
      n_checks++;
      if (dut.lfsr !== 16'h8000) begin n_fail++; $display("FAIL reset_mid_lfsr got=%h exp=8000", dut.lfsr); end
      n_checks++;
      if (dut.cnt !== 7'd16 || dut.half !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_cnt got=%0d/%b exp=16/0", dut.cnt, dut.half);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      m_lfsr = 16'h8000; m_ticks = 0;
      repeat (40) cycle(1'b1, 1'b0, 1'b0, 3'b000, 4'd3);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog t=%0t got=running exp=finished", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_periodic;
      test_white;
      test_ch2;
      test_back_to_back;
      test_vol_sweep;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
